// File: rtl/alu_multicycle_unit.sv
// alu_multicycle_unit: handshaked ALU with single-cycle ops and iterative multiply/divide.
// Results and flags are registered; MUL/DIV run one shift-add or restoring-subtract step per cycle.
module alu_multicycle_unit #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             In_Valid,
    output logic             In_Ready,
    input  logic [3:0]       ALUControl,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Out_Valid,
    input  logic             Out_Ready,
    output logic [WIDTH-1:0] ResultLo,
    output logic [WIDTH-1:0] ResultHi,
    output logic             Zero,
    output logic             Overflow,
    output logic             DivByZero
);
    localparam int SHW = $clog2(WIDTH);
    localparam int CNTW = $clog2(WIDTH) + 1;
    localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_MUL = 4'h2, OP_AND = 4'h3,
                           OP_OR = 4'h4, OP_SLT = 4'h5, OP_SEQ = 4'h6, OP_SNE = 4'h7,
                           OP_SRL = 4'h8, OP_SLL = 4'h9, OP_ROTR = 4'hA, OP_CLO = 4'hB,
                           OP_CLZ = 4'hC, OP_MULU = 4'hD, OP_DIV = 4'hE, OP_DIVU = 4'hF;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, state_nxt;

    logic [CNTW-1:0]    cnt;
    logic [WIDTH-1:0]   wh, wl, wb, a_raw;
    logic               op_div, neg_q, neg_r, dbz;
    logic               accept, is_multi, sgn, sa, sb;
    logic [WIDTH-1:0]   ma, mb, sum, dif, rot, sc_lo;
    logic               sc_ov;
    logic [SHW-1:0]     sh;
    logic [WIDTH:0]     msum, dsh, dtr;
    logic [WIDTH-1:0]   n_hi, n_lo, f_hi, f_lo;
    logic [2*WIDTH-1:0] prod, prodf;

    function automatic logic [CNTW-1:0] clz(input logic [WIDTH-1:0] x);
        clz = CNTW'(WIDTH);
        for (int i = 0; i < WIDTH; i++) if (x[i]) clz = CNTW'(WIDTH - 1 - i);
    endfunction

    assign In_Ready  = Reset && (state == IDLE || (state == DONE && Out_Ready));
    assign Out_Valid = state == DONE;
    assign accept    = In_Valid && In_Ready;
    assign is_multi  = ALUControl inside {OP_MUL, OP_MULU, OP_DIV, OP_DIVU};

    // Signed MUL/DIV iterate on magnitudes; the sign is restored on the final step
    assign sgn = ALUControl == OP_MUL || ALUControl == OP_DIV;
    assign sa  = sgn && A[WIDTH-1];
    assign sb  = sgn && B[WIDTH-1];
    assign ma  = sa ? -A : A;
    assign mb  = sb ? -B : B;

    assign sh  = B[SHW-1:0];
    assign sum = A + B;
    assign dif = A - B;
    assign rot = WIDTH'({A, A} >> sh);

    always_comb begin
        sc_lo = '0;
        sc_ov = 1'b0;
        case (ALUControl)
            OP_ADD:  begin sc_lo = sum; sc_ov = A[WIDTH-1] == B[WIDTH-1] && sum[WIDTH-1] != A[WIDTH-1]; end
            OP_SUB:  begin sc_lo = dif; sc_ov = A[WIDTH-1] != B[WIDTH-1] && dif[WIDTH-1] != A[WIDTH-1]; end
            OP_AND:  sc_lo = A & B;
            OP_OR:   sc_lo = A | B;
            OP_SLT:  sc_lo = WIDTH'($signed(A) < $signed(B));
            OP_SEQ:  sc_lo = WIDTH'(A == B);
            OP_SNE:  sc_lo = WIDTH'(A != B);
            OP_SRL:  sc_lo = A >> sh;
            OP_SLL:  sc_lo = A << sh;
            OP_ROTR: sc_lo = rot;
            OP_CLO:  sc_lo = WIDTH'(clz(~A));
            OP_CLZ:  sc_lo = WIDTH'(clz(A));
            default: sc_lo = '0;
        endcase
    end

    // wh:wl is the product/multiplier pair for MUL and remainder/dividend pair for DIV
    assign msum = {1'b0, wh} + (wl[0] ? {1'b0, wb} : '0);
    assign dsh  = {wh, wl[WIDTH-1]};
    assign dtr  = dsh - {1'b0, wb};
    assign n_hi = op_div ? (dtr[WIDTH] ? dsh[WIDTH-1:0] : dtr[WIDTH-1:0]) : msum[WIDTH:1];
    assign n_lo = op_div ? {wl[WIDTH-2:0], ~dtr[WIDTH]} : {msum[0], wl[WIDTH-1:1]};
    assign prod  = {n_hi, n_lo};
    assign prodf = neg_q ? -prod : prod;
    assign f_lo = !op_div ? prodf[WIDTH-1:0] : dbz ? '1 : neg_q ? -n_lo : n_lo;
    assign f_hi = !op_div ? prodf[2*WIDTH-1:WIDTH] : dbz ? a_raw : neg_r ? -n_hi : n_hi;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = is_multi ? BUSY : DONE;
            BUSY:    if (cnt == '0) state_nxt = DONE;
            DONE:    if (Out_Ready) state_nxt = !In_Valid ? IDLE : is_multi ? BUSY : DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            cnt       <= '0;
            wh        <= '0;
            wl        <= '0;
            wb        <= '0;
            a_raw     <= '0;
            op_div    <= 1'b0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            dbz       <= 1'b0;
            ResultLo  <= '0;
            ResultHi  <= '0;
            Zero      <= 1'b0;
            Overflow  <= 1'b0;
            DivByZero <= 1'b0;
        end else if (accept && is_multi) begin
            cnt    <= CNTW'(WIDTH - 1);
            wh     <= '0;
            wl     <= ma;
            wb     <= mb;
            a_raw  <= A;
            op_div <= ALUControl == OP_DIV || ALUControl == OP_DIVU;
            neg_q  <= sa ^ sb;
            neg_r  <= sa;
            dbz    <= (ALUControl == OP_DIV || ALUControl == OP_DIVU) && B == '0;
        end else if (accept) begin
            ResultLo  <= sc_lo;
            ResultHi  <= '0;
            Zero      <= sc_lo == '0;
            Overflow  <= sc_ov;
            DivByZero <= 1'b0;
        end else if (state == BUSY) begin
            wh <= n_hi;
            wl <= n_lo;
            if (cnt == '0) begin
                ResultLo  <= f_lo;
                ResultHi  <= f_hi;
                Zero      <= f_lo == '0;
                Overflow  <= 1'b0;
                DivByZero <= dbz;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_alu_multicycle_unit.sv
// tb_alu_multicycle_unit: directed self-checking bench for alu_multicycle_unit at WIDTH=32.
module tb_alu_multicycle_unit;
    logic        Clk = 1'b0, Reset = 1'b0, In_Valid = 1'b0, Out_Ready = 1'b1;
    logic [3:0]  ALUControl = 4'h0;
    logic [31:0] A = '0, B = '0;
    logic        In_Ready, Out_Valid, Zero, Overflow, DivByZero;
    logic [31:0] ResultLo, ResultHi;
    int          errors = 0, checks = 0;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a, b, lo, hi;
        logic        ov, dz;
    } vec_t;

    alu_multicycle_unit #(.WIDTH(32)) dut (
        .Clk(Clk), .Reset(Reset), .In_Valid(In_Valid), .In_Ready(In_Ready),
        .ALUControl(ALUControl), .A(A), .B(B), .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
        .ResultLo(ResultLo), .ResultHi(ResultHi), .Zero(Zero), .Overflow(Overflow),
        .DivByZero(DivByZero)
    );

    always #5 Clk = ~Clk;

    // n = edges after the accept edge until Out_Valid is seen (100 means it never came)
    task automatic run(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, output int n);
        ALUControl = op;
        A = a;
        B = b;
        In_Valid = 1'b1;
        @(posedge Clk); #1;
        In_Valid = 1'b0;
        n = 0;
        while (Out_Valid !== 1'b1 && n < 100) begin
            @(posedge Clk); #1;
            n++;
        end
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if ({Out_Valid, ResultLo, ResultHi, Zero, Overflow, DivByZero} !== '0)
            begin errors++; $display("FAIL reset_hold ov=%b lo=%h hi=%h z=%b o=%b d=%b, expected all 0", Out_Valid, ResultLo, ResultHi, Zero, Overflow, DivByZero); end
        repeat (2) @(posedge Clk);
        #1 Reset = 1'b1;
        #1;
        checks++;
        if (In_Ready !== 1'b1 || Out_Valid !== 1'b0 || ResultLo !== 32'h0 || Zero !== 1'b0)
            begin errors++; $display("FAIL reset_release in_ready=%b out_valid=%b lo=%h z=%b, expected 1 0 0 0", In_Ready, Out_Valid, ResultLo, Zero); end
    endtask

    task automatic test_alu;
        vec_t t [4] = '{
            '{4'h0, 32'h000003E8, 32'h00000112, 32'h000004FA, 32'h0, 1'b0, 1'b0},
            '{4'h0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 32'h0, 1'b1, 1'b0},
            '{4'h1, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 32'h0, 1'b1, 1'b0},
            '{4'h1, 32'h00000005, 32'h00000005, 32'h00000000, 32'h0, 1'b0, 1'b0}};
        int n;
        for (int i = 0; i < 4; i++) begin
            run(t[i].op, t[i].a, t[i].b, n);
            checks++;
            if ({ResultHi, ResultLo, Zero, Overflow, DivByZero} !== {t[i].hi, t[i].lo, t[i].lo == 32'h0, t[i].ov, t[i].dz} || n != 0)
                begin errors++; $display("FAIL alu[%0d] lo=%h hi=%h z=%b ov=%b dz=%b lat=%0d, expected lo=%h hi=%h ov=%b dz=%b lat=0", i, ResultLo, ResultHi, Zero, Overflow, DivByZero, n, t[i].lo, t[i].hi, t[i].ov, t[i].dz); end
        end
    endtask

    task automatic test_mul;
        vec_t t [5] = '{
            '{4'h2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b0},
            '{4'hD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b0, 1'b0},
            '{4'h2, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFF1, 32'hFFFFFFFF, 1'b0, 1'b0},
            '{4'hD, 32'h00000000, 32'h00001234, 32'h00000000, 32'h00000000, 1'b0, 1'b0},
            '{4'h2, 32'h80000000, 32'h80000000, 32'h00000000, 32'h40000000, 1'b0, 1'b0}};
        int n;
        for (int i = 0; i < 5; i++) begin
            run(t[i].op, t[i].a, t[i].b, n);
            checks++;
            if ({ResultHi, ResultLo, Zero, Overflow, DivByZero} !== {t[i].hi, t[i].lo, t[i].lo == 32'h0, t[i].ov, t[i].dz} || n != 32)
                begin errors++; $display("FAIL mul[%0d] lo=%h hi=%h z=%b ov=%b dz=%b lat=%0d, expected lo=%h hi=%h ov=%b dz=%b lat=32", i, ResultLo, ResultHi, Zero, Overflow, DivByZero, n, t[i].lo, t[i].hi, t[i].ov, t[i].dz); end
        end
    endtask

    task automatic test_div;
        vec_t t [7] = '{
            '{4'hE, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 1'b0},
            '{4'hF, 32'h00000007, 32'h00000000, 32'hFFFFFFFF, 32'h00000007, 1'b0, 1'b1},
            '{4'hE, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1'b0, 1'b0},
            '{4'hE, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001, 1'b0, 1'b0},
            '{4'hF, 32'h00000064, 32'h00000007, 32'h0000000E, 32'h00000002, 1'b0, 1'b0},
            '{4'hE, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFB, 1'b0, 1'b1},
            '{4'hF, 32'hFFFFFFFF, 32'h00000010, 32'h0FFFFFFF, 32'h0000000F, 1'b0, 1'b0}};
        int n;
        for (int i = 0; i < 7; i++) begin
            run(t[i].op, t[i].a, t[i].b, n);
            checks++;
            if ({ResultHi, ResultLo, Zero, Overflow, DivByZero} !== {t[i].hi, t[i].lo, t[i].lo == 32'h0, t[i].ov, t[i].dz} || n != 32)
                begin errors++; $display("FAIL div[%0d] lo=%h hi=%h z=%b ov=%b dz=%b lat=%0d, expected lo=%h hi=%h ov=%b dz=%b lat=32", i, ResultLo, ResultHi, Zero, Overflow, DivByZero, n, t[i].lo, t[i].hi, t[i].ov, t[i].dz); end
        end
    endtask

    task automatic test_shift_count;
        vec_t t [11] = '{
            '{4'hC, 32'h00000000, 32'h00000000, 32'h00000020, 32'h0, 1'b0, 1'b0},
            '{4'hB, 32'hFFFFFFF1, 32'h00000000, 32'h0000001C, 32'h0, 1'b0, 1'b0},
            '{4'hA, 32'h00000FED, 32'h0000000A, 32'hFB400003, 32'h0, 1'b0, 1'b0},
            '{4'h8, 32'h00000FED, 32'h00000021, 32'h000007F6, 32'h0, 1'b0, 1'b0},
            '{4'h9, 32'h00000001, 32'h0000001F, 32'h80000000, 32'h0, 1'b0, 1'b0},
            '{4'h5, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 32'h0, 1'b0, 1'b0},
            '{4'h5, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 32'h0, 1'b0, 1'b0},
            '{4'h6, 32'h00000005, 32'h00000005, 32'h00000001, 32'h0, 1'b0, 1'b0},
            '{4'h7, 32'h00000005, 32'h00000005, 32'h00000000, 32'h0, 1'b0, 1'b0},
            '{4'hC, 32'h00010000, 32'h00000000, 32'h0000000F, 32'h0, 1'b0, 1'b0},
            '{4'hB, 32'h00000000, 32'h00000000, 32'h00000000, 32'h0, 1'b0, 1'b0}};
        int n;
        for (int i = 0; i < 11; i++) begin
            run(t[i].op, t[i].a, t[i].b, n);
            checks++;
            if ({ResultHi, ResultLo, Zero, Overflow, DivByZero} !== {t[i].hi, t[i].lo, t[i].lo == 32'h0, t[i].ov, t[i].dz} || n != 0)
                begin errors++; $display("FAIL misc[%0d] lo=%h hi=%h z=%b ov=%b dz=%b lat=%0d, expected lo=%h hi=%h lat=0", i, ResultLo, ResultHi, Zero, Overflow, DivByZero, n, t[i].lo, t[i].hi); end
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0]  op [3] = '{4'h3, 4'h4, 4'h5};
        logic [31:0] ex [3] = '{32'h0000F000, 32'h0000FFF0, 32'h00000001};
        Out_Ready = 1'b1;
        A = 32'h0000F0F0;
        B = 32'h0000FF00;
        In_Valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ALUControl = op[i];
            if (i == 2) begin A = 32'hFFFFFFFF; B = 32'h00000001; end
            @(posedge Clk); #1;
            checks++;
            if (Out_Valid !== 1'b1 || ResultLo !== ex[i])
                begin errors++; $display("FAIL b2b[%0d] out_valid=%b lo=%h, expected 1 %h", i, Out_Valid, ResultLo, ex[i]); end
        end
        In_Valid = 1'b0;
    endtask

    task automatic test_backpressure;
        @(posedge Clk); #1;
        Out_Ready = 1'b0;
        ALUControl = 4'h1;
        A = 32'h00000112;
        B = 32'h000003E8;
        In_Valid = 1'b1;
        @(posedge Clk); #1;
        ALUControl = 4'h0;
        A = 32'h00000001;
        B = 32'h00000002;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (Out_Valid !== 1'b1 || In_Ready !== 1'b0 || ResultLo !== 32'hFFFFFD2A || ResultHi !== 32'h0)
                begin errors++; $display("FAIL hold[%0d] out_valid=%b in_ready=%b lo=%h hi=%h, expected 1 0 fffffd2a 0", i, Out_Valid, In_Ready, ResultLo, ResultHi); end
            @(posedge Clk); #1;
        end
        Out_Ready = 1'b1;
        #1;
        checks++;
        if (In_Ready !== 1'b1 || ResultLo !== 32'hFFFFFD2A)
            begin errors++; $display("FAIL release in_ready=%b lo=%h, expected 1 fffffd2a", In_Ready, ResultLo); end
        @(posedge Clk); #1;
        In_Valid = 1'b0;
        checks++;
        if (Out_Valid !== 1'b1 || ResultLo !== 32'h00000003)
            begin errors++; $display("FAIL second out_valid=%b lo=%h, expected 1 00000003", Out_Valid, ResultLo); end
        @(posedge Clk); #1;
        checks++;
        if (Out_Valid !== 1'b0 || In_Ready !== 1'b1)
            begin errors++; $display("FAIL drain out_valid=%b in_ready=%b, expected 0 1", Out_Valid, In_Ready); end
    endtask

    task automatic test_reset_abort;
        int  n;
        logic quiet = 1'b1;
        ALUControl = 4'hF;
        A = 32'd100;
        B = 32'd7;
        In_Valid = 1'b1;
        @(posedge Clk); #1;
        In_Valid = 1'b0;
        repeat (9) @(posedge Clk);
        #1;
        checks++;
        if (In_Ready !== 1'b0 || Out_Valid !== 1'b0)
            begin errors++; $display("FAIL busy in_ready=%b out_valid=%b, expected 0 0", In_Ready, Out_Valid); end
        Reset = 1'b0;
        #1;
        checks++;
        if ({Out_Valid, ResultLo, ResultHi, Zero, Overflow, DivByZero} !== '0)
            begin errors++; $display("FAIL abort_clear out_valid=%b lo=%h hi=%h z=%b o=%b d=%b, expected all 0", Out_Valid, ResultLo, ResultHi, Zero, Overflow, DivByZero); end
        repeat (2) @(posedge Clk);
        #1 Reset = 1'b1;
        #1;
        checks++;
        if (In_Ready !== 1'b1 || Out_Valid !== 1'b0)
            begin errors++; $display("FAIL abort_release in_ready=%b out_valid=%b, expected 1 0", In_Ready, Out_Valid); end
        repeat (40) begin
            @(posedge Clk); #1;
            if (Out_Valid !== 1'b0) quiet = 1'b0;
        end
        checks++;
        if (quiet !== 1'b1)
            begin errors++; $display("FAIL abort_discard out_valid rose after reset, expected 0 throughout"); end
        run(4'h0, 32'd1, 32'd1, n);
        checks++;
        if (ResultLo !== 32'd2 || n != 0)
            begin errors++; $display("FAIL post_reset_add lo=%h lat=%0d, expected 00000002 0", ResultLo, n); end
    endtask

    initial begin
        test_reset;
        test_alu;
        test_mul;
        test_div;
        test_shift_count;
        test_back_to_back;
        test_backpressure;
        test_reset_abort;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end
endmodule
